// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_e;

    localparam int PC_INCR    = 4;
    // Signed so that a cast to a wider PC sign-extends into an all-ones upper mask.
    localparam int ALIGN_MASK = ~32'h3;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs one req/gnt/rvalid access at a time,
// buffers the returned word and offers it to the instruction register.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                   DATAWIDTH = 32,
    parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 run_i,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [DATAWIDTH-1:0] redirect_pc_i,
    output logic                 imem_req_o,
    output logic [DATAWIDTH-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [DATAWIDTH-1:0] imem_rdata_i,
    output logic [DATAWIDTH-1:0] instr_o,
    output logic [DATAWIDTH-1:0] instr_pc_o,
    output logic                 ir_en_o,
    output logic [DATAWIDTH-1:0] pc_o,
    output logic                 busy_o
);

    fetch_state_e         state_q, state_d;
    logic [DATAWIDTH-1:0] pc_q, pc_d;
    logic [DATAWIDTH-1:0] addr_q, addr_d;
    logic [DATAWIDTH-1:0] instr_q, instr_d;
    logic [DATAWIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                 kill_q, kill_d;
    logic                 release_slot;
    logic [DATAWIDTH-1:0] target;

    assign target = redirect_pc_i & DATAWIDTH'(ALIGN_MASK);

    always_comb begin
        // NOTE: every _d starts as its _q, so no branch can leave a latch behind.
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        kill_d       = kill_q;
        release_slot = 1'b0;

        if (redirect_i) begin
            pc_d = target;
        end

        case (state_q)
            IDLE: release_slot = 1'b1;
            REQ: begin
                if (redirect_i) kill_d = 1'b1;
                if (imem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    if (kill_q || redirect_i) begin
                        kill_d       = 1'b0;
                        release_slot = 1'b1;
                    end else begin
                        instr_d    = imem_rdata_i;
                        instr_pc_d = addr_q;
                        pc_d       = pc_q + DATAWIDTH'(PC_INCR);
                        state_d    = HOLD;
                    end
                end else if (redirect_i) begin
                    // The access in flight cannot be cancelled; mark its data as stale.
                    kill_d = 1'b1;
                end
            end
            HOLD: release_slot = redirect_i || !stall_i;
            default: state_d = IDLE;
        endcase

        // The slot is free: start the next access at the freshly updated PC, or park.
        if (release_slot) begin
            state_d = run_i ? REQ : IDLE;
            if (run_i) addr_d = pc_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            kill_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            kill_q     <= kill_d;
        end
    end

    assign imem_req_o  = (state_q == REQ);
    assign imem_addr_o = addr_q;
    assign instr_o     = instr_q;
    assign instr_pc_o  = instr_pc_q;
    assign ir_en_o     = (state_q == HOLD) && !stall_i && !redirect_i;
    assign pc_o        = pc_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level model of the fetch stream.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h100;

    logic        clk_i, rst_ni;
    logic        run_i, stall_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic [31:0] instr_o, instr_pc_o, pc_o;
    logic        ir_en_o, busy_o;

    fetch_unit #(.DATAWIDTH(32), .RESET_PC(RPC)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o), .ir_en_o(ir_en_o),
        .pc_o(pc_o), .busy_o(busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: every word is distinct and 0x100 holds 0xAAAA0001.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a - 32'h100 + 32'hAAAA0001;
    endfunction

    // ---------------- memory responder ----------------
    bit          rand_delays = 0, spur_en = 0;
    int          gnt_delay = 0, rv_delay = 0;
    bit          s_grant;
    logic [31:0] s_addr;

    always @(negedge clk_i) begin
        s_grant = imem_req_o && imem_gnt_i && rst_ni;
        s_addr  = imem_addr_o;
    end

    initial begin
        bit          pend;
        logic [31:0] paddr;
        int          cnt, req_cycles, cur_gd;
        pend = 0; cnt = 0; req_cycles = 0; cur_gd = 0; paddr = '0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
        forever begin
            @(posedge clk_i); #1;
            if (s_grant) begin
                pend  = 1;
                paddr = s_addr;
                cnt   = rand_delays ? int'($urandom_range(0, 3)) : rv_delay;
            end
            imem_rvalid_i = 0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rvalid_i = 1;
                    imem_rdata_i  = mem_f(paddr);
                    pend          = 0;
                end else begin
                    cnt--;
                end
            end else if (spur_en && $urandom_range(0, 5) == 0) begin
                imem_rvalid_i = 1;
                imem_rdata_i  = $urandom;
            end
            if (imem_req_o) begin
                if (req_cycles == 0) cur_gd = rand_delays ? int'($urandom_range(0, 3)) : gnt_delay;
                imem_gnt_i = (req_cycles >= cur_gd);
                req_cycles++;
            end else begin
                imem_gnt_i = 0;
                req_cycles = 0;
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    // Tracks: expected PC, the request being presented, the one access in flight
    // (and whether a redirect has made it stale), and the word waiting for delivery.
    logic [31:0] m_pc = RPC, m_req_addr = '0, m_out_addr = '0, m_instr = '0, m_ipc = '0;
    bit          m_exp_req = 0, m_req_cont = 0, m_req_live = 0;
    bit          m_out = 0, m_live = 0, m_pend = 0;
    int          pulse_cnt = 0, req_start_cnt = 0;

    always @(negedge clk_i) begin : model
        logic [31:0] tgt;
        bit          deliver, accept;
        if (!rst_ni) begin
            check("rst pc_o", pc_o, RPC);
            check("rst imem_addr_o", imem_addr_o, RPC);
            check("rst instr_o", instr_o, 32'h0);
            check("rst instr_pc_o", instr_pc_o, 32'h0);
            check("rst req/ir_en/busy", {imem_req_o, ir_en_o, busy_o}, 3'b000);
            m_pc = RPC; m_exp_req = 0; m_req_cont = 0; m_out = 0; m_pend = 0;
        end else begin
            tgt = redirect_pc_i & ~32'h3;
            check("pc_o", pc_o, m_pc);
            check("imem_req_o", imem_req_o, m_exp_req);
            if (imem_req_o) begin
                if (!m_req_cont) begin
                    m_req_addr = m_pc;
                    m_req_live = 1;
                    req_start_cnt++;
                end
                check("imem_addr_o", imem_addr_o, m_req_addr);
                if (redirect_i) m_req_live = 0;
            end
            deliver = m_pend && !stall_i && !redirect_i;
            check("ir_en_o", ir_en_o, deliver);
            if (m_pend) begin
                check("instr_o", instr_o, m_instr);
                check("instr_pc_o", instr_pc_o, m_ipc);
            end
            check("busy_o", busy_o, imem_req_o || m_out || m_pend);
            if (ir_en_o) pulse_cnt++;

            if (m_pend && (deliver || redirect_i)) m_pend = 0;
            accept = 0;
            if (m_out && imem_rvalid_i) begin
                m_out = 0;
                if (m_live && !redirect_i) begin
                    accept  = 1;
                    m_pend  = 1;
                    m_instr = mem_f(m_out_addr);
                    m_ipc   = m_out_addr;
                end
            end else if (m_out && redirect_i) begin
                m_live = 0;
            end
            if (imem_req_o && imem_gnt_i) begin
                m_out      = 1;
                m_live     = m_req_live;
                m_out_addr = m_req_addr;
            end
            if (redirect_i)  m_pc = tgt;
            else if (accept) m_pc = m_pc + 32'd4;
            m_req_cont = imem_req_o && !imem_gnt_i;
            m_exp_req  = m_req_cont || (!m_out && !m_pend && run_i);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_i); #1;
    endtask

    task automatic do_reset();
        rst_ni = 0; run_i = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = '0;
        repeat (2) step();
        rst_ni = 1;
    endtask

    // Waits (bounded) for a DUT/bus event; returns at the negedge where it is seen.
    task automatic wait_event(input int kind, input string name);
        bit hit = 0;
        for (int i = 0; i < 64 && !hit; i++) begin
            @(negedge clk_i);
            case (kind)
                0: hit = imem_req_o && imem_gnt_i;
                1: hit = imem_rvalid_i;
                2: hit = imem_req_o;
                default: hit = ir_en_o;
            endcase
        end
        check({name, " reached"}, {31'b0, hit}, 32'd1);
    endtask

    initial begin
        int base, rs;
        rst_ni = 0; run_i = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = '0;

        // Zero-wait fetch: REQ, WAIT, HOLD+pulse, next REQ.
        do_reset();
        run_i = 1;
        @(negedge clk_i);
        @(negedge clk_i);
        check("t1 req", imem_req_o, 1'b1);
        check("t1 addr", imem_addr_o, 32'h100);
        @(negedge clk_i);
        check("t1 wait req/ir_en", {imem_req_o, ir_en_o}, 2'b00);
        @(negedge clk_i);
        check("t1 ir_en", ir_en_o, 1'b1);
        check("t1 instr", instr_o, 32'hAAAA0001);
        check("t1 instr_pc", instr_pc_o, 32'h100);
        check("t1 pc", pc_o, 32'h104);
        @(negedge clk_i);
        check("t1 next req", imem_req_o, 1'b1);
        check("t1 next addr", imem_addr_o, 32'h104);
        step(); run_i = 0;
        repeat (10) step();

        // Slow memory, run dropped while in REQ: one access completes, then idle.
        do_reset();
        gnt_delay = 3; rv_delay = 2;
        base = pulse_cnt; rs = req_start_cnt;
        run_i = 1;
        wait_event(2, "t2 req");
        step(); run_i = 0;
        repeat (15) step();
        check("t2 pulses", pulse_cnt - base, 32'd1);
        check("t2 requests", req_start_cnt - rs, 32'd1);
        check("t2 pc", pc_o, 32'h104);
        check("t2 idle", busy_o, 1'b0);
        gnt_delay = 0; rv_delay = 0;

        // Stall for 4 cycles in HOLD.
        do_reset();
        stall_i = 1; run_i = 1;
        wait_event(1, "t3 rvalid");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("t3 stalled ir_en", ir_en_o, 1'b0);
            check("t3 held instr", instr_o, 32'hAAAA0001);
            check("t3 no req", imem_req_o, 1'b0);
        end
        step(); stall_i = 0;
        @(negedge clk_i);
        check("t3 release ir_en", ir_en_o, 1'b1);
        step(); run_i = 0;
        repeat (6) step();

        // Redirect in WAIT to an unaligned target.
        do_reset();
        rv_delay = 2; run_i = 1;
        wait_event(0, "t4 grant");
        step(); redirect_i = 1; redirect_pc_i = 32'h203;
        base = pulse_cnt;
        step(); redirect_i = 0;
        wait_event(2, "t4 req");
        check("t4 addr", imem_addr_o, 32'h200);
        step();
        check("t4 no pulse", pulse_cnt - base, 32'd0);
        wait_event(3, "t4 ir_en");
        check("t4 instr_pc", instr_pc_o, 32'h200);
        check("t4 instr", instr_o, 32'hAAAA0101);
        step(); run_i = 0; rv_delay = 0;
        repeat (8) step();

        // Redirect in HOLD, then redirect coincident with rvalid.
        do_reset();
        stall_i = 1; run_i = 1;
        wait_event(1, "t5 rvalid");
        step(); redirect_i = 1; redirect_pc_i = 32'h300;
        @(negedge clk_i);
        check("t5 hold redirect ir_en", ir_en_o, 1'b0);
        step(); redirect_i = 0; stall_i = 0;
        wait_event(2, "t5 req");
        check("t5 addr", imem_addr_o, 32'h300);
        wait_event(3, "t5 ir_en");
        check("t5 instr_pc", instr_pc_o, 32'h300);
        wait_event(0, "t5 grant");
        step(); redirect_i = 1; redirect_pc_i = 32'h400;
        base = pulse_cnt;
        @(negedge clk_i);
        check("t5 coincident ir_en", ir_en_o, 1'b0);
        step(); redirect_i = 0;
        wait_event(2, "t5 req2");
        check("t5 addr2", imem_addr_o, 32'h400);
        step();
        check("t5 no pulse", pulse_cnt - base, 32'd0);
        wait_event(3, "t5 ir_en2");
        check("t5 instr_pc2", instr_pc_o, 32'h400);
        step(); run_i = 0;
        repeat (6) step();

        // PC wrap at the top of the address space.
        do_reset();
        redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFF;
        step(); redirect_i = 0;
        @(negedge clk_i);
        check("t6 pc", pc_o, 32'hFFFF_FFFC);
        step(); run_i = 1;
        wait_event(3, "t6 ir_en");
        check("t6 instr_pc", instr_pc_o, 32'hFFFF_FFFC);
        check("t6 instr", instr_o, 32'hAAA9_FEFD);
        check("t6 wrapped pc", pc_o, 32'h0);
        wait_event(2, "t6 req");
        check("t6 addr", imem_addr_o, 32'h0);
        step(); run_i = 0;
        repeat (6) step();

        // Reset asserted in WAIT; the late response must be ignored.
        do_reset();
        rv_delay = 3; run_i = 1;
        wait_event(0, "t7 grant");
        step(); rst_ni = 0; run_i = 0;
        #1;
        check("t7 pc", pc_o, RPC);
        check("t7 addr", imem_addr_o, RPC);
        check("t7 req/ir_en/busy", {imem_req_o, ir_en_o, busy_o}, 3'b000);
        step(); rst_ni = 1;
        base = pulse_cnt;
        repeat (8) step();
        check("t7 no pulse", pulse_cnt - base, 32'd0);
        check("t7 idle", busy_o, 1'b0);
        check("t7 instr", instr_o, 32'h0);
        check("t7 instr_pc", instr_pc_o, 32'h0);
        rv_delay = 0;

        // Randomized traffic with random latencies and stray responses.
        do_reset();
        rand_delays = 1; spur_en = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c == 1500) begin
                rst_ni = 0;
                step();
                rst_ni = 1;
            end
            run_i      = ($urandom_range(0, 15) != 0);
            stall_i    = ($urandom_range(0, 3) == 0);
            redirect_i = ($urandom_range(0, 11) == 0);
            redirect_pc_i = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                       : $urandom;
        end
        run_i = 0; stall_i = 0; redirect_i = 0;
        repeat (12) step();
        check("final idle", busy_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the simple multi-cycle CPU. It owns the program counter, issues one word read at a time on a request/grant/response instruction-memory port, and buffers the returned word. It then presents the word with a one-cycle load pulse to the downstream instruction register, honouring stall and branch/jump redirect from the control path.

## Interface
- `DATAWIDTH`, 32: width of PC, address and instruction.
- `RESET_PC`, 0: PC value after reset. Bits [1:0] must be zero.

- `clk_i`  in  1: clock, rising edge.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `run_i`  in  1: fetch enable. Low means finish the current access, then go idle.
- `stall_i`  in  1: downstream cannot accept an instruction this cycle.
- `redirect_i`  in  1: branch/jump taken this cycle.
- `redirect_pc_i`  in  DATAWIDTH: redirect target.
- `imem_req_o`  out  1: memory request.
- `imem_addr_o`  out  DATAWIDTH: request address, word-aligned.
- `imem_gnt_i`  in  1: request accepted this cycle.
- `imem_rvalid_i`  in  1: read data valid.
- `imem_rdata_i`  in  DATAWIDTH: read data.
- `instr_o`  out  DATAWIDTH: buffered instruction.
- `instr_pc_o`  out  DATAWIDTH: address of `instr_o`.
- `ir_en_o`  out  1: load pulse to the instruction register.
- `pc_o`  out  DATAWIDTH: next fetch address.
- `busy_o`  out  1: high whenever state is not IDLE.

## Operation
- Reset values:
  - State is IDLE.
  - `pc_o` = `imem_addr_o` = RESET_PC.
  - `instr_o`, `instr_pc_o`, `imem_req_o`, `ir_en_o`, `busy_o` = 0.
  - kill flag = 0.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: `imem_req_o` low. If `run_i`, latch `imem_addr_o` <= pc and go to REQ.
  - REQ: `imem_req_o` high. `imem_addr_o` is held stable until grant. On `imem_gnt_i`, go to WAIT.
  - WAIT: `imem_req_o` low. On `imem_rvalid_i`:
    - If kill flag is set or `redirect_i` is high: discard the data, clear kill flag, then go to REQ (latching the new pc) if `run_i`, else IDLE.
    - Otherwise: `instr_o` <= rdata, `instr_pc_o` <= `imem_addr_o`, pc <= pc + 4, go to HOLD.
  - HOLD: `ir_en_o` = !`stall_i` && !`redirect_i` (combinational).
    - When `ir_en_o` is high, leave to REQ (latch address) if `run_i`, else IDLE.
    - While `stall_i` is high, stay in HOLD; `instr_o` is held.
- Redirect. The target is aligned as `redirect_pc_i` with bits [1:0] forced to 0. It has priority over increment in every state.
  - IDLE: pc <= target.
  - REQ or WAIT without same-cycle rvalid: pc <= target and kill flag <= 1. The outstanding access completes and its data is discarded.
  - WAIT with same-cycle rvalid: data discarded, pc <= target.
  - HOLD: buffered instruction discarded, `ir_en_o` stays low, pc <= target, go to REQ/IDLE.
- `run_i` falling in REQ or WAIT does not abort the access. The response is delivered through HOLD, then the FSM goes to IDLE.
- Only one access is ever outstanding. An `imem_rvalid_i` outside WAIT is ignored.
- Reset asserted mid-access returns everything to reset values. Late responses are ignored by the rule above.

## Timing
- Zero-wait memory (grant in the first REQ cycle, rvalid the next cycle):
  - REQ at cycle n, WAIT at n+1, HOLD with `ir_en_o` at n+2, next REQ at n+3.
  - Peak throughput is one instruction per 3 cycles.
- `instr_o`/`instr_pc_o` are valid from the first HOLD cycle until the next capture.
- `pc_o` updates on the rvalid edge (increment) or on the redirect edge.
- `ir_en_o` is high for exactly one cycle per delivered instruction.
- PC arithmetic is modulo 2^DATAWIDTH: 0xFFFF_FFFC + 4 wraps to 0.

## Structure
- Package `fetch_pkg`:
  - state enum `fetch_state_e` {IDLE, REQ, WAIT, HOLD}
  - `PC_INCR` = 4
  - `ALIGN_MASK` = ~32'h3
- Single module. No sub-module is needed; the instruction buffer and PC are plain registers inside it.

## Test plan
- Reset with RESET_PC=0x100, then `run_i`=1 with a zero-wait memory returning 0xAAAA0001 -> `imem_addr_o`=0x100. `ir_en_o` pulses at the 3rd cycle with `instr_o`=0xAAAA0001 and `instr_pc_o`=0x100. The next request is at 0x104.
- Grant delayed 3 cycles and rvalid delayed 2 cycles -> `imem_addr_o` is stable throughout REQ. Exactly one `ir_en_o` pulse; `pc_o` goes 0x100 to 0x104.
- `stall_i` high for 4 cycles in HOLD -> `ir_en_o` low and `instr_o` unchanged. `ir_en_o` pulses on the cycle `stall_i` drops; no new request is issued during the stall.
- `redirect_i` with target 0x203 while in WAIT -> returned data is discarded with no `ir_en_o`. The next request goes to 0x200.
- Redirect in HOLD, and redirect coincident with rvalid -> no pulse for the discarded word. The fetch resumes at the target.
- `run_i` dropped in REQ, `rst_ni` asserted in WAIT, and PC at 0xFFFF_FFFC:
  - Dropped `run_i`: the access completes, one pulse, then IDLE.
  - Reset in WAIT: all outputs return to reset values immediately, and a later rvalid is ignored.
  - PC at 0xFFFF_FFFC: the next PC is 0.
